key_conditioner: RTL and testbench
==================================

# key_conditioner

Front-end conditioning stage for the DE2 pushbuttons, placed between the raw `KEY` pins and the game logic. Each active-low button is synchronised to `CLK`, debounced with a per-key stability counter, and converted to an active-high level plus single-cycle press, release and auto-repeat pulses. The game core consumes these clean one-cycle events instead of raw bouncing switch levels.

## Interface
- `N_KEYS`, 4: number of independent buttons.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a change (10 ms at 50 MHz); must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from an accepted press to the first repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses; must be ≥ 1.

Ports:
- `CLK` input 1: system clock; the only clock.
- `RST` input 1: reset, synchronous, active-high (driven from `SW[17]` at board level).
- `KEY_N` input `N_KEYS`: raw buttons, active-low, asynchronous to `CLK`.
- `PRESSED` output `N_KEYS`: debounced level, 1 = held.
- `PRESS_PULSE` output `N_KEYS`: one-cycle pulse on an accepted press.
- `RELEASE_PULSE` output `N_KEYS`: one-cycle pulse on an accepted release.
- `REPEAT_PULSE` output `N_KEYS`: one-cycle auto-repeat pulse while held.

## Operation
- Per key, fully independent. Keys never interact, and simultaneous events on different keys are all reported in the same cycle.
- Synchroniser: two flops per key, reset to 1 (released). The inverted second-stage output is the sample `s`.
- Debounce: stable state `st` (reset 0) and counter `cnt` (reset 0, width `$clog2(DEBOUNCE_CYCLES+1)`).
  - If `s == st`, `cnt` is cleared to 0.
  - If `s != st` and `cnt < DEBOUNCE_CYCLES-1`, `cnt` increments.
  - If `s != st` and `cnt == DEBOUNCE_CYCLES-1`, `st` toggles and `cnt` is cleared.
  - A single glitch sample equal to `st` restarts the count.
- `PRESSED = st`, registered.
- On a 0→1 transition of `st`, `PRESS_PULSE` is high for exactly the cycle in which `st` first reads 1.
- On a 1→0 transition of `st`, `RELEASE_PULSE` is high for exactly the cycle in which `st` first reads 0.
- Auto-repeat state machine, per key:
  - IDLE → on press acceptance, load repeat counter with `REPEAT_DELAY`, go to WAIT. If `REPEAT_DELAY` is 0, stay in IDLE.
  - WAIT → decrement each cycle. On reaching 1, assert `REPEAT_PULSE` next cycle, reload with `REPEAT_PERIOD`, go to RUN.
  - RUN → same decrement/pulse/reload loop with `REPEAT_PERIOD`.
  - Any state → IDLE in the cycle release is accepted. `REPEAT_PULSE` is never high in the same cycle as `RELEASE_PULSE` or `PRESS_PULSE` on that key.
- Repeat counter width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`. It never underflows or wraps.
- A key held through reset deassertion is treated as a new press: synchroniser starts at released, so a press is accepted after the normal latency.

## Timing
- Reset values: all synchroniser flops 1; `st`, `cnt`, repeat counters 0; FSM IDLE. All four outputs are 0 during reset and in the first cycle after `RST` falls.
- Reset mid-operation: state is cleared at the next edge with `RST`=1. No pulse is emitted because of the forced clear.
- Press/release latency: `KEY_N` change first sampled at edge t and held. `PRESSED` changes and the event pulse is high after edge t + 1 + `DEBOUNCE_CYCLES`.
- Release latency is identical to press latency.
- Repeat: first `REPEAT_PULSE` high after edge p + `REPEAT_DELAY`, where p is the edge on which `PRESS_PULSE` rose. Later pulses follow every `REPEAT_PERIOD` edges.
- All pulses are exactly one cycle wide. All outputs are registered, with no combinational path from `KEY_N`.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- Clean press: `KEY_N[0]` driven low before edge 0 and held.
  - `PRESSED[0]` rises and `PRESS_PULSE[0]` is high for one cycle after edge 5.
  - No activity on keys 1–3.
- Bounce: `KEY_N[1]` toggles low/high/low/high/low on edges 0–4, then held low.
  - Exactly one `PRESS_PULSE[1]`, after edge 9.
  - No `RELEASE_PULSE`.
- Auto-repeat then release: hold key 2 with press accepted at edge p.
  - `REPEAT_PULSE[2]` after p+10, p+13, p+16.
  - Release sampled at p+17 gives `RELEASE_PULSE[2]` after p+22, with no repeat at p+22.
- Simultaneous: all keys pressed at edge 0.
  - `PRESS_PULSE` = 4'b1111 for one cycle after edge 5.
  - Releasing key 3 alone yields `RELEASE_PULSE` = 4'b1000.
- Reset mid-count: key 0 pressed at edge 0, `RST`=1 at edge 3 for one cycle.
  - No pulse around the reset.
  - With the key still low, press is accepted 5 edges after the first post-reset sample.
- Repeat disabled: rerun scenario 3 with `REPEAT_DELAY`=0.
  - Zero `REPEAT_PULSE` over 50 held cycles.

Source files
------------

// File: rtl/key_conditioner.sv
// Pushbutton front end: per-key synchroniser, stability-counter debounce, and
// registered press / release / auto-repeat event pulses for the game core.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY_N,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PRESS_PULSE,
  output logic [N_KEYS-1:0] RELEASE_PULSE,
  output logic [N_KEYS-1:0] REPEAT_PULSE
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RUN  = 2'd2
  } rpt_state_e;

  logic [N_KEYS-1:0] sync1_d, sync1_q;
  logic [N_KEYS-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = KEY_N;
    sync2_d = sync1_q;
  end

  // Synchroniser resets to "released" so a key held through reset is seen as a new press
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic             s;
    logic             st_d, st_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    rpt_state_e       state_d, state_q;
    logic [RPT_W-1:0] rcnt_d, rcnt_q;
    logic             press_d, press_q;
    logic             rel_d, rel_q;
    logic             rpt_d, rpt_q;

    assign s = ~sync2_q[k];

    always_comb begin
      st_d    = st_q;
      cnt_d   = '0;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;
      state_d = state_q;
      rcnt_d  = rcnt_q;

      // Any sample matching the stable state (including a single glitch) restarts the count
      if (s != st_q) begin
        if (cnt_q == CNT_LAST) begin
          st_d    = s;
          press_d = s;
          rel_d   = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      case (state_q)
        R_IDLE: begin
          if (press_d && (REPEAT_DELAY != 0)) begin
            state_d = R_WAIT;
            rcnt_d  = RPT_DELAY_V;
          end
        end
        R_WAIT, R_RUN: begin
          // Release wins over a coincident repeat so the two never overlap
          if (rel_d) begin
            state_d = R_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RPT_ONE) begin
            rpt_d   = 1'b1;
            rcnt_d  = RPT_PERIOD_V;
            state_d = R_RUN;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = R_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        st_q    <= 1'b0;
        cnt_q   <= '0;
        state_q <= R_IDLE;
        rcnt_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
      end
    end

    assign PRESSED[k]       = st_q;
    assign PRESS_PULSE[k]   = press_q;
    assign RELEASE_PULSE[k] = rel_q;
    assign REPEAT_PULSE[k]  = rpt_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing; a second
// instance with auto-repeat disabled shares the same stimulus.
module tb_key_conditioner;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] KEY_N = 4'b1111;

  logic [3:0] pressed, press_p, rel_p, rpt_p;
  logic [3:0] pressed0, press_p0, rel_p0, rpt_p0;

  int n_assert = 0;
  int n_fail   = 0;

  int press_tot[4] = '{default: 0};
  int rel_tot[4]   = '{default: 0};
  int rpt_tot[4]   = '{default: 0};
  int rpt0_tot     = 0;

  key_conditioner #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY_N(KEY_N),
    .PRESSED(pressed), .PRESS_PULSE(press_p),
    .RELEASE_PULSE(rel_p), .REPEAT_PULSE(rpt_p)
  );

  key_conditioner #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) dut0 (
    .CLK(CLK), .RST(RST), .KEY_N(KEY_N),
    .PRESSED(pressed0), .PRESS_PULSE(press_p0),
    .RELEASE_PULSE(rel_p0), .REPEAT_PULSE(rpt_p0)
  );

  always #5 CLK = ~CLK;

  // Running pulse totals, sampled mid-cycle
  always @(negedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      press_tot[k] = press_tot[k] + int'(press_p[k]);
      rel_tot[k]   = rel_tot[k] + int'(rel_p[k]);
      rpt_tot[k]   = rpt_tot[k] + int'(rpt_p[k]);
      rpt0_tot     = rpt0_tot + int'(rpt_p0[k]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pressed"}, pressed, 4'b0000);
    chk({tag, "_press"}, press_p, 4'b0000);
    chk({tag, "_rel"}, rel_p, 4'b0000);
    chk({tag, "_rpt"}, rpt_p, 4'b0000);
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    KEY_N = 4'b1111;
    tick(2);
    chk_idle("rst_during");
    RST = 1'b0;
    tick(1);
    chk_idle("rst_after");
  endtask

  initial begin
    int p0, r0, snap_rpt2, snap_rpt0;
    logic [3:0] exp_v;

    // Clean press on key 0
    do_reset();
    KEY_N = 4'b1110;
    tick(5);
    chk("s1_pressed_e4", pressed, 4'b0000);
    tick(1);
    chk("s1_pressed_e5", pressed, 4'b0001);
    chk("s1_press_e5", press_p, 4'b0001);
    chk("s1_rel_e5", rel_p, 4'b0000);
    tick(1);
    chk("s1_press_e6", press_p, 4'b0000);
    chk("s1_pressed_e6", pressed, 4'b0001);

    // Bounce on key 1: samples 0,1,0,1,0 on edges 0..4 then held low
    do_reset();
    p0 = press_tot[1];
    r0 = rel_tot[1];
    for (int e = 0; e <= 12; e++) begin
      if (e <= 4) KEY_N[1] = e[0];
      tick(1);
      if (e == 8) chk("s2_pressed_e8", pressed, 4'b0000);
      if (e == 9) begin
        chk("s2_press_e9", press_p, 4'b0010);
        chk("s2_pressed_e9", pressed, 4'b0010);
      end
    end
    chk_n("s2_press_count", press_tot[1] - p0, 1);
    chk_n("s2_rel_count", rel_tot[1] - r0, 0);

    // Auto-repeat on key 2, press accepted at edge 5, release sampled at edge 22
    do_reset();
    KEY_N = 4'b1011;
    for (int e = 0; e <= 30; e++) begin
      if (e == 22) KEY_N = 4'b1111;
      tick(1);
      exp_v = (e == 15 || e == 18 || e == 21 || e == 24) ? 4'b0100 : 4'b0000;
      chk($sformatf("s3_rpt_e%0d", e), rpt_p, exp_v);
      exp_v = (e == 27) ? 4'b0100 : 4'b0000;
      chk($sformatf("s3_rel_e%0d", e), rel_p, exp_v);
      exp_v = (e == 5) ? 4'b0100 : 4'b0000;
      chk($sformatf("s3_press_e%0d", e), press_p, exp_v);
      exp_v = (e >= 5 && e <= 26) ? 4'b0100 : 4'b0000;
      chk($sformatf("s3_pressed_e%0d", e), pressed, exp_v);
    end

    // Simultaneous press of all keys, then release of key 3 alone
    do_reset();
    KEY_N = 4'b0000;
    tick(5);
    chk("s4_pressed_e4", pressed, 4'b0000);
    tick(1);
    chk("s4_press_e5", press_p, 4'b1111);
    chk("s4_pressed_e5", pressed, 4'b1111);
    KEY_N = 4'b1000;
    tick(1);
    chk("s4_press_e6", press_p, 4'b0000);
    tick(4);
    chk("s4_pressed_e10", pressed, 4'b1111);
    chk("s4_rel_e10", rel_p, 4'b0000);
    tick(1);
    chk("s4_rel_e11", rel_p, 4'b1000);
    chk("s4_pressed_e11", pressed, 4'b0111);
    chk("s4_rpt_e11", rpt_p, 4'b0000);
    chk("s4_press_e11", press_p, 4'b0000);
    tick(1);
    chk("s4_rel_e12", rel_p, 4'b0000);

    // Reset mid-count: key 0 low from edge 0, RST high on edge 3 only
    do_reset();
    p0 = press_tot[0];
    r0 = rel_tot[0];
    KEY_N = 4'b1110;
    for (int e = 0; e <= 10; e++) begin
      RST = (e == 3);
      tick(1);
      if (e >= 3 && e <= 8) chk_idle($sformatf("s5_e%0d", e));
      if (e == 9) begin
        chk("s5_press_e9", press_p, 4'b0001);
        chk("s5_pressed_e9", pressed, 4'b0001);
      end
    end
    RST = 1'b0;
    chk_n("s5_press_count", press_tot[0] - p0, 1);
    chk_n("s5_rel_count", rel_tot[0] - r0, 0);

    // Repeat disabled instance: key 2 held for 50+ cycles
    do_reset();
    snap_rpt2 = rpt_tot[2];
    snap_rpt0 = rpt0_tot;
    KEY_N = 4'b1011;
    tick(6);
    chk("s6_press0_e5", press_p0, 4'b0100);
    tick(50);
    chk("s6_pressed0", pressed0, 4'b0100);
    tick(1);
    chk_n("s6_rpt0_count", rpt0_tot - snap_rpt0, 0);
    chk_n("s6_rpt_count_enabled", rpt_tot[2] - snap_rpt2, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
